// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, oversampling ratio,
// default frame and divider parameters, and a counter-width helper.
package uart_pkg;

  localparam int unsigned OVERSAMPLE        = 16;
  localparam int unsigned DEFAULT_DATA_BITS = 8;
  localparam int unsigned DEFAULT_SB_TICKS  = 16;
  localparam int unsigned DEFAULT_BAUD_DIV  = 651;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  // Width needed to count 0..n-1; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle pulse every BAUD_DIV clocks, restartable via clear.
module baud_tick_gen import uart_pkg::*; #(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned    CntW   = cnt_width(BAUD_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter fed from a show-ahead FIFO: start bit, LSB-first data, SB_TICKS of stop,
// with zero-gap back-to-back frames while the FIFO has data.
module uart_tx_unit import uart_pkg::*; #(
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS,
  parameter int unsigned SB_TICKS  = DEFAULT_SB_TICKS,
  parameter int unsigned BAUD_DIV  = DEFAULT_BAUD_DIV
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int unsigned TickMax = (SB_TICKS > OVERSAMPLE) ? SB_TICKS : OVERSAMPLE;
  localparam int unsigned TickW   = cnt_width(TickMax);
  localparam int unsigned BitW    = cnt_width(DATA_BITS);

  localparam logic [TickW-1:0] TickLastBit  = TickW'(OVERSAMPLE - 1);
  localparam logic [TickW-1:0] TickLastStop = TickW'(SB_TICKS - 1);
  localparam logic [BitW-1:0]  BitLast      = BitW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]      bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 fifo_read_q, fifo_read_d;
  logic                 tick;
  logic                 start_frame;

  baud_tick_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(start_frame),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    fifo_read_d = 1'b0;
    start_frame = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d        = 1'b1;
        start_frame = !fifo_empty;
      end
      StStart: begin
        if (tick) begin
          if (tick_cnt_q == TickLastBit) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            tx_d       = shift_q[0];
            state_d    = StData;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (tick_cnt_q == TickLastBit) begin
            tick_cnt_d = '0;
            shift_d    = shift_q >> 1;
            if (bit_idx_q == BitLast) begin
              tx_d    = 1'b1;
              state_d = StStop;
            end else begin
              tx_d      = shift_d[0];
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (tick_cnt_q == TickLastStop) begin
            tick_cnt_d = '0;
            if (!fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Capture the head word at the pop edge so later FIFO changes cannot disturb the frame.
    if (start_frame) begin
      shift_d     = fifo_data;
      fifo_read_d = 1'b1;
      tx_d        = 1'b0;
      tick_cnt_d  = '0;
      state_d     = StStart;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
      fifo_read_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      fifo_read_q <= fifo_read_d;
    end
  end

  assign tx        = tx_q;
  assign fifo_read = fifo_read_q;
  assign tx_busy   = (state_q != StIdle);

endmodule

// File: doc/uart_tx_unit.md
UART_TX_UNIT -- requirements
Module: uart_tx_unit

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame.
REQ-002 Parameter SB_TICKS, default 16: stop-bit length in oversample ticks (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 Parameter BAUD_DIV, default 651: clk cycles per oversample tick (100 MHz, 9600 baud, 16x oversampling).
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 fifo_empty  input  1  source FIFO has no data; fifo_data is invalid while high.
REQ-007 fifo_data  input  DATA_BITS  head word of the source FIFO; valid whenever fifo_empty is low.
REQ-008 fifo_read  output  1  pop request to the FIFO; registered, one clk cycle wide per word.
REQ-009 tx  output  1  serial line; registered; idles high.
REQ-010 tx_busy  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-011 FSM states: IDLE, START, DATA, STOP.
REQ-012 Oversample tick: single-cycle pulse every BAUD_DIV clk cycles; divider cleared to 0 on every edge that enters START.
REQ-013 IDLE with fifo_empty low at an edge: at that edge shift register <= fifo_data, fifo_read <= 1, tx <= 0, tick count <= 0, state <= START.
REQ-014 fifo_read drops at the next edge; it is never asserted while fifo_empty is high and never twice for one word.
REQ-015 START: tx = 0 for 16 ticks, then tx <= shift[0], bit index <= 0, state <= DATA.
REQ-016 DATA: each bit is held for 16 ticks, LSB first; after each bit the register shifts right one place; after bit DATA_BITS-1, tx <= 1 and state <= STOP.
REQ-017 STOP: tx = 1 for SB_TICKS ticks.
REQ-018 STOP end with fifo_empty low: same action as REQ-013 (zero-gap back-to-back frames).
REQ-019 STOP end with fifo_empty high: state <= IDLE.
REQ-020 Each state advances on the edge where tick = 1 and tick count = (limit-1); tick count resets to 0 on each advance.
REQ-021 Bit time: exactly 16*BAUD_DIV clk cycles.
REQ-022 Frame time: (1+DATA_BITS)*16*BAUD_DIV + SB_TICKS*BAUD_DIV clk cycles.
REQ-023 Latency: fifo_empty falling, sampled in IDLE, gives tx low and fifo_read high one clk later.
REQ-024 fifo_data changes after the pop have no effect on the frame in progress.
REQ-025 Counter widths: tick count sized for max(16, SB_TICKS); bit index sized by clog2(DATA_BITS); divider sized by clog2(BAUD_DIV); all counters wrap only by explicit clear.

Reset
REQ-026 reset sets: state = IDLE, tx = 1, fifo_read = 0, tx_busy = 0; shift register, tick count, bit index and divider = 0.
REQ-027 reset mid-frame aborts the frame immediately with tx high; no pop is issued for the aborted word; the next word starts a complete frame after reset is released.

Structure
REQ-028 Shared package uart_pkg holds: state encoding constants, OVERSAMPLE = 16, default DATA_BITS and BAUD_DIV.
REQ-029 The divider is a sub-module baud_tick_gen with ports clk, reset, clear and tick, and parameter BAUD_DIV.
REQ-030 Total RTL: 120-400 lines.

Verification (bench overrides BAUD_DIV = 4)
REQ-031 Single word 0x55 in FIFO: one fifo_read pulse; tx = 0,1,0,1,0,1,0,1,0,1 per 64-cycle bit; frame of 640 cycles; tx_busy then falls.
REQ-032 Words 0xA3 and 0x0F queued: the second start bit begins on the cycle after the first stop bit ends; exactly 2 fifo_read pulses; decoded bytes are 0xA3 and 0x0F.
REQ-033 fifo_empty held high for 10000 cycles: tx stays 1, fifo_read stays 0, tx_busy stays 0.
REQ-034 reset asserted during DATA bit 3 of 0xFF: tx = 1 asynchronously; after release, the queued 0x3C is sent as a full 640-cycle frame.
REQ-035 SB_TICKS = 32, word 0x00: stop level lasts 128 cycles; frame of 704 cycles.
REQ-036 fifo_data changed to 0xFF right after the pop of 0x12: the line still carries 0x12.
